uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver; the receive end of the same 8N1 link the team's transmitter drives.
- Oversamples `rx_in` on `bclk`, validates the start bit at mid-bit, samples each data bit at its centre, and checks the stop bit.
- Delivers each byte through a Receiver Hold Register (RHR) with a ready/read handshake.
- Reports framing and overrun errors to the host-side controller.

Parameters:
- SPB, 16, bclk cycles per serial bit (oversample ratio); even, >= 4.

Ports:
- bclk  input  1  oversample clock (SPB x baud rate); all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- rx_in  input  1  serial line; idle high; format: start(0), d0..d7 LSB first, stop(1).
- rd  input  1  host read strobe; one-cycle pulse consumes RHR.
- d_out  output  8  RHR contents.
- rx_ready  output  1  RHR holds an unread byte.
- rx_busy  output  1  high whenever FSM is not IDLE.
- frame_err  output  1  sticky; stop bit sampled as 0.
- overrun_err  output  1  sticky; byte completed while previous byte unread.

Behaviour:
- Reset (reset=0, asynchronous):
  - d_out=0x00, rx_ready=0, rx_busy=0, frame_err=0, overrun_err=0.
  - Both synchronizer flops =1, FSM=IDLE, counters=0.
- Synchronizer: `rx_in` passes through 2 flops to give `rx_s`; only `rx_s` is used internally.
- Counters: sample counter, width clog2(SPB); bit index, 3 bits.
- IDLE:
  - rx_s==0 -> START, sample counter=0.
- START:
  - Increment counter each cycle.
  - At the cycle where counter==SPB/2-1: rx_s==0 -> DATA (counter=0, bit index=0).
  - At that cycle, rx_s==1 -> false start, back to IDLE with no flags touched.
- DATA:
  - Increment counter.
  - At counter==SPB-1: shift rx_s into the MSB of the shift register (right shift), counter=0, bit index+1.
  - After the 8th sample -> STOP.
- STOP:
  - At counter==SPB-1, sample rx_s, then go to IDLE immediately (mid stop bit, allows resync).
  - rx_s==1: RHR <= shift register, rx_ready=1.
    - If rx_ready was already 1 and rd is not asserted this cycle: overrun_err=1, RHR is overwritten with the new byte.
  - rx_s==0: frame_err=1; RHR and rx_ready unchanged; the byte is discarded.
- Latency (SPB=16): with the rx_in falling edge just before bclk edge 0, rx_ready and the new d_out are visible after edge 155:
  - 2 cycles synchronizer.
  - 1 cycle IDLE detect.
  - 8 cycles START.
  - 128 cycles DATA.
  - 16 cycles STOP.
- rd handshake:
  - rd=1 clears rx_ready, frame_err and overrun_err on the next edge.
  - d_out holds its value after being read.
- Simultaneous rd and valid stop-sample in the same cycle: the load wins. rx_ready stays 1, RHR takes the new byte, no overrun. frame_err and overrun_err are cleared.
- rd while rx_ready=0: only clears the error flags; no other effect.
- rx_in held low continuously (break): a frame of 0x00 fails the stop check, so frame_err=1. FSM then re-enters START as soon as rx_s is still 0 in IDLE.
- Back-to-back frames with no idle gap: the next start bit is detected from IDLE with no lost frame.
- Reset mid-frame: abort immediately, all state goes to reset values, and no partial byte is loaded.

Test Plan:
- Reset, then send 0xA5 at SPB=16 (tx bit period 16 bclk) -> rx_ready rises after edge 155, d_out=0xA5, frame_err=0. Pulse rd -> rx_ready=0, d_out stays 0xA5.
- Send 0x00 then 0xFF back-to-back, pulsing rd after each byte -> two rx_ready events with d_out 0x00 then 0xFF, no errors.
- Glitch: rx_in low for 4 bclk, then high -> rx_busy pulses, returns to IDLE, rx_ready=0, no flags set.
- Frame 0x3C with stop bit forced 0 -> frame_err=1, rx_ready=0, d_out unchanged. rd clears frame_err.
- Receive 0x11 without rd, then 0x22 -> overrun_err=1, rx_ready=1, d_out=0x22. Repeat with rd asserted on the exact load cycle -> no overrun.
- Assert reset during DATA bit 4 of a frame -> all outputs at reset values immediately. The next clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with oversampling, receiver hold register and error flags
//
// Recovers bytes from an oversampled 8N1 serial line. The start bit is
// validated at its midpoint; from there every data bit and the stop bit are
// sampled one full bit period apart, which lands each sample near a bit centre.
//
// Ports:
//   bclk        oversample clock, SPB cycles per serial bit
//   reset       asynchronous active-low reset
//   rx_in       serial line, idle high
//   rd          host read strobe, consumes the hold register
//   d_out       receiver hold register contents
//   rx_ready    hold register holds an unread byte
//   rx_busy     a frame is being received
//   frame_err   sticky, stop bit sampled low
//   overrun_err sticky, byte completed while the previous one was unread

module uart_receiver #(
    parameter int SPB = 16
) (
    input  logic       bclk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       rd,
    output logic [7:0] d_out,
    output logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun_err
);

    localparam int CW = $clog2(SPB);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [CW-1:0] HALF_LAST = CW'(SPB / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(SPB - 1);

    logic          sync_1;
    logic          rx_s;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    logic stop_sample;
    logic load;
    logic stop_bad;

    // Stop bit is judged at its centre; the FSM returns to IDLE right away so a
    // following start edge is not missed even if the sender's clock runs fast.
    assign stop_sample = (state == STOP) && (cnt == FULL_LAST);
    assign load        = stop_sample && rx_s;
    assign stop_bad    = stop_sample && !rx_s;
    assign rx_busy     = (state != IDLE);

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge bclk or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_1 <= rx_in;
            rx_s   <= sync_1;
        end
    end

    always_ff @(posedge bclk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        // A line that is high again by mid start bit was a glitch.
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt     <= '0;
                        // LSB arrives first, so shifting right leaves d0 in bit 0.
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == FULL_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Host-side hold register and flags. A load in the same cycle as rd takes
    // priority for rx_ready: the host read the old byte, the new one is unread.
    always_ff @(posedge bclk or negedge reset) begin
        if (!reset) begin
            d_out       <= '0;
            rx_ready    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (load) begin
                d_out <= shreg;
            end

            if (load) begin
                rx_ready <= 1'b1;
            end else if (rd) begin
                rx_ready <= 1'b0;
            end

            if (stop_bad) begin
                frame_err <= 1'b1;
            end else if (rd) begin
                frame_err <= 1'b0;
            end

            if (load && rx_ready && !rd) begin
                overrun_err <= 1'b1;
            end else if (rd) begin
                overrun_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver

module tb_uart_receiver;

    localparam int SPB      = 16;
    localparam int FRAME    = 10 * SPB;
    localparam int LOAD_C   = 154;
    localparam int READY_C  = 155;

    logic       bclk;
    logic       reset;
    logic       rx_in;
    logic       rd;
    logic [7:0] d_out;
    logic       rx_ready;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun_err;

    int vectors;
    int miscompares;

    // Reference model of the host-visible state
    logic       m_ready;
    logic [7:0] m_dout;
    logic       m_ferr;
    logic       m_oerr;

    uart_receiver #(.SPB(SPB)) dut (
        .bclk        (bclk),
        .reset       (reset),
        .rx_in       (rx_in),
        .rd          (rd),
        .d_out       (d_out),
        .rx_ready    (rx_ready),
        .rx_busy     (rx_busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired, got running, required finished");
        $fatal(1);
    end

    // Drives one frame starting at the next falling edge. Cycle c is the bclk
    // edge count since the start bit was put on the line; rd is high during
    // edge rd_at. Reports the cycle at which rx_ready was first seen rising.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int rd_at,
                              input int ncyc, output int ready_c, output logic [7:0] ready_byte);
        logic [9:0] bits;
        logic       prev;
        bits       = {stop_bit, data, 1'b0};
        prev       = rx_ready;
        ready_c    = -1;
        ready_byte = 8'h00;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge bclk);
            if (!prev && rx_ready && ready_c < 0) begin
                ready_c    = c;
                ready_byte = d_out;
            end
            prev = rx_ready;
            if (c % SPB == 0) rx_in = bits[c / SPB];
            rd = (c == rd_at);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge bclk);
            rx_in = 1'b1;
            rd    = 1'b0;
        end
    endtask

    task automatic pulse_rd();
        @(negedge bclk);
        rx_in = 1'b1;
        rd    = 1'b1;
        @(negedge bclk);
        rd    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx_in = 1'b1;
        rd    = 1'b0;
        repeat (3) @(negedge bclk);
        vectors++;
        if ({d_out, rx_ready, rx_busy, frame_err, overrun_err} !== 12'h000) begin
            $display("FAIL reset_outputs: got d_out=%02h rdy=%b busy=%b ferr=%b oerr=%b, required all zero",
                     d_out, rx_ready, rx_busy, frame_err, overrun_err);
            miscompares++;
        end
        reset = 1'b1;
        idle(4);
    endtask

    task automatic test_basic();
        int         rc;
        logic [7:0] rb;
        send_frame(8'hA5, 1'b1, -1, FRAME, rc, rb);
        vectors++;
        if (rc !== READY_C) begin
            $display("FAIL basic_latency: got %0d, required %0d", rc, READY_C);
            miscompares++;
        end
        vectors++;
        if (rb !== 8'hA5) begin
            $display("FAIL basic_data: got %02h, required a5", rb);
            miscompares++;
        end
        vectors++;
        if (frame_err !== 1'b0 || overrun_err !== 1'b0) begin
            $display("FAIL basic_flags: got ferr=%b oerr=%b, required 0 0", frame_err, overrun_err);
            miscompares++;
        end
        pulse_rd();
        vectors++;
        if (rx_ready !== 1'b0 || d_out !== 8'hA5) begin
            $display("FAIL basic_read: got rdy=%b d_out=%02h, required 0 a5", rx_ready, d_out);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        int         rc0, rc1;
        logic [7:0] rb0, rb1;
        send_frame(8'h00, 1'b1, 157, FRAME, rc0, rb0);
        send_frame(8'hFF, 1'b1, 157, FRAME, rc1, rb1);
        vectors++;
        if (rc0 !== READY_C || rb0 !== 8'h00) begin
            $display("FAIL b2b_first: got cycle %0d byte %02h, required %0d 00", rc0, rb0, READY_C);
            miscompares++;
        end
        vectors++;
        if (rc1 !== READY_C || rb1 !== 8'hFF) begin
            $display("FAIL b2b_second: got cycle %0d byte %02h, required %0d ff", rc1, rb1, READY_C);
            miscompares++;
        end
        vectors++;
        if (frame_err !== 1'b0 || overrun_err !== 1'b0 || rx_ready !== 1'b0) begin
            $display("FAIL b2b_flags: got ferr=%b oerr=%b rdy=%b, required 0 0 0",
                     frame_err, overrun_err, rx_ready);
            miscompares++;
        end
        idle(4);
    endtask

    task automatic test_glitch();
        logic busy_seen;
        busy_seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge bclk);
            if (rx_busy) busy_seen = 1'b1;
            rx_in = (c >= 4);
        end
        vectors++;
        if (busy_seen !== 1'b1 || rx_busy !== 1'b0) begin
            $display("FAIL glitch_busy: got seen=%b now=%b, required 1 0", busy_seen, rx_busy);
            miscompares++;
        end
        vectors++;
        if (rx_ready !== 1'b0 || frame_err !== 1'b0 || overrun_err !== 1'b0) begin
            $display("FAIL glitch_flags: got rdy=%b ferr=%b oerr=%b, required 0 0 0",
                     rx_ready, frame_err, overrun_err);
            miscompares++;
        end
    endtask

    task automatic test_frame_err();
        int         rc;
        logic [7:0] rb;
        send_frame(8'h3C, 1'b0, -1, FRAME, rc, rb);
        idle(40);
        vectors++;
        if (frame_err !== 1'b1 || rx_ready !== 1'b0 || d_out !== 8'hFF) begin
            $display("FAIL ferr_set: got ferr=%b rdy=%b d_out=%02h, required 1 0 ff",
                     frame_err, rx_ready, d_out);
            miscompares++;
        end
        pulse_rd();
        vectors++;
        if (frame_err !== 1'b0) begin
            $display("FAIL ferr_clear: got %b, required 0", frame_err);
            miscompares++;
        end
    endtask

    task automatic test_overrun();
        int         rc;
        logic [7:0] rb;
        send_frame(8'h11, 1'b1, -1, FRAME, rc, rb);
        send_frame(8'h22, 1'b1, -1, FRAME, rc, rb);
        vectors++;
        if (overrun_err !== 1'b1 || rx_ready !== 1'b1 || d_out !== 8'h22) begin
            $display("FAIL overrun_set: got oerr=%b rdy=%b d_out=%02h, required 1 1 22",
                     overrun_err, rx_ready, d_out);
            miscompares++;
        end
        pulse_rd();
        vectors++;
        if (overrun_err !== 1'b0 || rx_ready !== 1'b0) begin
            $display("FAIL overrun_clear: got oerr=%b rdy=%b, required 0 0", overrun_err, rx_ready);
            miscompares++;
        end
        send_frame(8'h33, 1'b1, -1, FRAME, rc, rb);
        send_frame(8'h44, 1'b1, LOAD_C, FRAME, rc, rb);
        vectors++;
        if (overrun_err !== 1'b0 || rx_ready !== 1'b1 || d_out !== 8'h44) begin
            $display("FAIL rd_on_load: got oerr=%b rdy=%b d_out=%02h, required 0 1 44",
                     overrun_err, rx_ready, d_out);
            miscompares++;
        end
        pulse_rd();
    endtask

    task automatic test_reset_mid();
        int         rc;
        logic [7:0] rb;
        send_frame(8'h77, 1'b1, -1, FRAME, rc, rb);
        // Stop partway through data bit 4 (line bit 5)
        send_frame(8'h99, 1'b1, -1, 5 * SPB + 8, rc, rb);
        vectors++;
        if (rx_busy !== 1'b1 || rx_ready !== 1'b1) begin
            $display("FAIL mid_before: got busy=%b rdy=%b, required 1 1", rx_busy, rx_ready);
            miscompares++;
        end
        #1;
        reset = 1'b0;
        #1;
        vectors++;
        if ({d_out, rx_ready, rx_busy, frame_err, overrun_err} !== 12'h000) begin
            $display("FAIL mid_reset: got d_out=%02h rdy=%b busy=%b ferr=%b oerr=%b, required all zero",
                     d_out, rx_ready, rx_busy, frame_err, overrun_err);
            miscompares++;
        end
        rx_in = 1'b1;
        idle(3);
        reset = 1'b1;
        idle(10);
        send_frame(8'h5A, 1'b1, -1, FRAME, rc, rb);
        vectors++;
        if (rc !== READY_C || rb !== 8'h5A || frame_err !== 1'b0 || overrun_err !== 1'b0) begin
            $display("FAIL mid_recover: got cycle %0d byte %02h ferr=%b oerr=%b, required %0d 5a 0 0",
                     rc, rb, frame_err, overrun_err, READY_C);
            miscompares++;
        end
        pulse_rd();
    endtask

    task automatic test_random();
        int         rc, exp_rc, rd_at, pick;
        logic [7:0] rb, data;
        logic       good;
        m_ready = 1'b0;
        m_dout  = 8'h5A;
        m_ferr  = 1'b0;
        m_oerr  = 1'b0;
        for (int n = 0; n < 40; n++) begin
            data = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            pick = $urandom_range(0, 2);
            rd_at = (pick == 0) ? -1 : (pick == 1 && good) ? LOAD_C : 157;
            send_frame(data, good, rd_at, FRAME, rc, rb);

            exp_rc = (good && !m_ready && rd_at != LOAD_C) ? READY_C :
                     (good && !m_ready) ? READY_C : -1;
            if (good) begin
                if (rd_at == LOAD_C) begin
                    m_ferr = 1'b0;
                    m_oerr = 1'b0;
                end else if (m_ready) begin
                    m_oerr = 1'b1;
                end
                m_ready = 1'b1;
                m_dout  = data;
            end else begin
                m_ferr = 1'b1;
            end
            if (rd_at == 157) begin
                m_ready = 1'b0;
                m_ferr  = 1'b0;
                m_oerr  = 1'b0;
            end

            vectors++;
            if (rx_ready !== m_ready || d_out !== m_dout || frame_err !== m_ferr ||
                overrun_err !== m_oerr || rc !== exp_rc) begin
                $display("FAIL random_%0d: got rdy=%b d=%02h ferr=%b oerr=%b rc=%0d, required %b %02h %b %b %0d",
                         n, rx_ready, d_out, frame_err, overrun_err, rc,
                         m_ready, m_dout, m_ferr, m_oerr, exp_rc);
                miscompares++;
            end
            idle(good ? $urandom_range(0, 8) : 40);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
